// File: rtl/sd_spi_responder.sv
// SD-card-side SPI responder: oversampled mode-0 slave that decodes 48-bit commands,
// answers R1/R3/R7 and serves CMD17 block reads. Optional CRC7 check: SD_RESP_CRC7_CHECK_EN.
module sd_spi_responder #(
  parameter int unsigned NCR_BYTES         = 1,
  parameter int unsigned NAC_BYTES         = 2,
  parameter int unsigned ACMD41_BUSY_COUNT = 2,
  parameter int unsigned BLOCK_BYTES       = 512
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        sd_clk,
  input  logic        sd_mosi,
  input  logic        sd_cs_n,
  output logic        sd_miso,
  output logic        cmd_strobe,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_idle
);

  typedef enum logic [2:0] {HUNT, RX_CMD, NCR, RESP, NAC, TOKEN, DATA, DCRC} state_t;

  localparam int unsigned       IDX_W  = $clog2(BLOCK_BYTES + 1);
  localparam logic [3:0]        NCR_N  = 4'(NCR_BYTES);
  localparam logic [3:0]        NAC_N  = 4'(NAC_BYTES);
  localparam logic [3:0]        ACMD_N = 4'(ACMD41_BUSY_COUNT);
  localparam logic [IDX_W-1:0]  BLK_N  = IDX_W'(BLOCK_BYTES);

  logic [1:0] sck_sync, mosi_sync, cs_sync;
  logic       sck_prev;
  logic       sck_rise, sck_fall, cs_n_s, mosi_s;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic       byte_done;

  state_t            state;
  logic [3:0]        cnt;
  logic [37:0]       frame;
  logic [39:0]       resp_buf;
  logic [3:0]        resp_len;
  logic              data_pend;
  logic [7:0]        tx_next, tx_shift;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        data_val;
  logic [15:0]       crc;
  logic              app_flag;
  logic [3:0]        acmd_cnt;

  logic [7:0]  r1;
  logic [31:0] resp_tail;
  logic        resp_long, want_data, nxt_idle, nxt_app;
  logic [3:0]  nxt_acmd, acmd_inc;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic [7:0]  bb;
    logic        fb;
    c  = c_in;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[15] ^ bb[7];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      bb = {bb[6:0], 1'b0};
    end
    return c;
  endfunction

`ifdef SD_RESP_CRC7_CHECK_EN
  logic crc_bad;

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0]  c;
    logic [39:0] dd;
    logic        fb;
    c  = '0;
    dd = d;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = c[6] ^ dd[39];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      dd = {dd[38:0], 1'b0};
    end
    return c;
  endfunction

  // Byte 0 always carries start bits 01, so they are not kept in the frame register.
  assign crc_bad = (rx_byte[7:1] != crc7_40({2'b01, frame})) | ~rx_byte[0];
`endif

  assign sck_rise  = sck_sync[1] & ~sck_prev;
  assign sck_fall  = ~sck_sync[1] & sck_prev;
  assign cs_n_s    = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign rx_byte   = {rx_shift, mosi_s};
  assign byte_done = sck_rise & ~cs_n_s & (bit_cnt == 3'd7);
  assign sd_miso   = tx_shift[7];

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_prev  <= 1'b0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
    end else begin
      sck_sync  <= {sck_sync[0], sd_clk};
      mosi_sync <= {mosi_sync[0], sd_mosi};
      cs_sync   <= {cs_sync[0], sd_cs_n};
      sck_prev  <= sck_sync[1];
      if (cs_n_s) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte[6:0];
      end
    end
  end

  always_comb begin
    r1        = {5'b0, 1'b1, 1'b0, card_idle};
    resp_tail = '0;
    resp_long = 1'b0;
    want_data = 1'b0;
    nxt_idle  = card_idle;
    nxt_app   = 1'b0;
    nxt_acmd  = acmd_cnt;
    acmd_inc  = (acmd_cnt >= ACMD_N) ? acmd_cnt : acmd_cnt + 4'd1;
    case (frame[37:32])
      6'd0: begin
        r1       = 8'h01;
        nxt_idle = 1'b1;
        nxt_acmd = '0;
      end
      6'd8: begin
        r1        = {7'b0, card_idle};
        resp_long = 1'b1;
        resp_tail = {20'h0, frame[11:0]};
      end
      6'd55: begin
        r1      = {7'b0, card_idle};
        nxt_app = 1'b1;
      end
      6'd41: begin
        if (app_flag) begin
          nxt_acmd = acmd_inc;
          if (acmd_inc == ACMD_N) begin
            nxt_idle = 1'b0;
            r1       = 8'h00;
          end else begin
            r1 = 8'h01;
          end
        end
      end
      6'd58: begin
        r1        = {7'b0, card_idle};
        resp_long = 1'b1;
        resp_tail = 32'hC0FF_8000;
      end
      6'd17: begin
        r1        = card_idle ? 8'h05 : 8'h00;
        want_data = ~card_idle;
      end
      default: ;
    endcase
`ifdef SD_RESP_CRC7_CHECK_EN
    if (crc_bad) begin
      r1        = {4'b0, 1'b1, 2'b0, card_idle};
      resp_long = 1'b0;
      want_data = 1'b0;
      nxt_idle  = card_idle;
      nxt_app   = app_flag;
      nxt_acmd  = acmd_cnt;
    end
`endif
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      cnt        <= '0;
      frame      <= '0;
      resp_buf   <= '0;
      resp_len   <= '0;
      data_pend  <= 1'b0;
      tx_next    <= '1;
      tx_shift   <= '1;
      idx        <= '0;
      data_val   <= '0;
      crc        <= '0;
      cmd_strobe <= 1'b0;
      cmd_index  <= '0;
      cmd_arg    <= '0;
      card_idle  <= 1'b1;
      app_flag   <= 1'b0;
      acmd_cnt   <= '0;
    end else begin
      cmd_strobe <= 1'b0;
      if (cs_n_s) begin
        state    <= HUNT;
        tx_next  <= '1;
        tx_shift <= '1;
      end else begin
        // tx_next is chosen at the end of each byte and goes out from the following SCK fall.
        if (sck_fall)
          tx_shift <= (bit_cnt == 3'd0) ? tx_next : {tx_shift[6:0], 1'b1};
        if (byte_done) begin
          case (state)
            HUNT: begin
              tx_next <= '1;
              if (rx_byte[7:6] == 2'b01) begin
                frame <= {frame[29:0], rx_byte};
                cnt   <= 4'd1;
                state <= RX_CMD;
              end
            end
            RX_CMD: begin
              if (cnt == 4'd5) begin
                cmd_strobe <= 1'b1;
                cmd_index  <= frame[37:32];
                cmd_arg    <= frame[31:0];
                card_idle  <= nxt_idle;
                acmd_cnt   <= nxt_acmd;
                app_flag   <= nxt_app;
                resp_buf   <= {r1, resp_tail};
                resp_len   <= resp_long ? 4'd5 : 4'd1;
                data_pend  <= want_data;
                tx_next    <= '1;
                cnt        <= 4'd1;
                state      <= NCR;
              end else begin
                frame <= {frame[29:0], rx_byte};
                cnt   <= cnt + 4'd1;
              end
            end
            NCR: begin
              if (cnt == NCR_N) begin
                tx_next  <= resp_buf[39:32];
                resp_buf <= {resp_buf[31:0], 8'hFF};
                cnt      <= 4'd1;
                state    <= RESP;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
            RESP: begin
              if (cnt == resp_len) begin
                if (!data_pend) begin
                  tx_next <= '1;
                  state   <= HUNT;
                end else if (NAC_BYTES == 0) begin
                  tx_next <= 8'hFE;
                  state   <= TOKEN;
                end else begin
                  tx_next <= '1;
                  cnt     <= 4'd1;
                  state   <= NAC;
                end
              end else begin
                tx_next  <= resp_buf[39:32];
                resp_buf <= {resp_buf[31:0], 8'hFF};
                cnt      <= cnt + 4'd1;
              end
            end
            NAC: begin
              if (cnt == NAC_N) begin
                tx_next <= 8'hFE;
                state   <= TOKEN;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
            TOKEN: begin
              tx_next  <= cmd_arg[7:0];
              data_val <= cmd_arg[7:0] + 8'd1;
              crc      <= crc16_byte(16'h0000, cmd_arg[7:0]);
              idx      <= IDX_W'(1);
              state    <= DATA;
            end
            DATA: begin
              if (idx == BLK_N) begin
                tx_next <= crc[15:8];
                cnt     <= 4'd1;
                state   <= DCRC;
              end else begin
                tx_next  <= data_val;
                crc      <= crc16_byte(crc, data_val);
                data_val <= data_val + 8'd1;
                idx      <= idx + IDX_W'(1);
              end
            end
            DCRC: begin
              if (cnt == 4'd2) begin
                tx_next <= '1;
                state   <= HUNT;
              end else begin
                tx_next <= crc[7:0];
                cnt     <= 4'd2;
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: SPI master model with an expected-MISO-byte scoreboard,
// a command table for card initialisation and hand-written CMD17/abort/reset sequences.
module tb_sd_spi_responder;

  logic        clk25 = 1'b0;
  logic        rst_n = 1'b0;
  logic        sd_clk = 1'b0;
  logic        sd_mosi = 1'b1;
  logic        sd_cs_n = 1'b1;
  logic        sd_miso;
  logic        cmd_strobe;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        card_idle;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    string       name;
    logic [39:0] frame;
    int unsigned nresp;
    logic [39:0] resp;
    logic        idle_after;
  } vec_t;

  vec_t vecs[12];

  sd_spi_responder dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .sd_clk     (sd_clk),
    .sd_mosi    (sd_mosi),
    .sd_cs_n    (sd_cs_n),
    .sd_miso    (sd_miso),
    .cmd_strobe (cmd_strobe),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .card_idle  (card_idle)
  );

  always #5 clk25 = ~clk25;

  always @(posedge clk25) if (cmd_strobe) strobe_cnt <= strobe_cnt + 1;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc7_byte(input logic [39:0] f);
    logic [6:0] c = '0;
    for (int i = 39; i >= 0; i--) begin
      logic fb;
      fb = c[6] ^ f[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {c, 1'b1};
  endfunction

  function automatic logic [15:0] crc16_model(input logic [7:0] start, input int unsigned n);
    logic [15:0] c = '0;
    logic [7:0]  b = start;
    for (int unsigned k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        logic fb;
        fb = c[15] ^ b[i];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
      b = b + 8'd1;
    end
    return c;
  endfunction

  // Mode 0 master: MOSI set while SCK low, MISO sampled just before the rising edge.
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic [7:0] r = '0;
    for (int i = 7; i >= 0; i--) begin
      sd_mosi = tx[i];
      wait_clk(4);
      r = {r[6:0], sd_miso};
      sd_clk = 1'b1;
      wait_clk(4);
      sd_clk = 1'b0;
    end
    rx = r;
  endtask

  task automatic xfer(input logic [7:0] tx, input string name);
    logic [7:0] rx, exp;
    spi_byte(tx, rx);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %02h with no byte expected", name, rx);
    end else begin
      exp = exp_q.pop_front();
      check(name, {24'h0, rx}, {24'h0, exp});
    end
  endtask

  task automatic send_frame(input logic [39:0] f, input logic [7:0] crcb, input string name);
    logic [39:0] t = f;
    for (int k = 0; k < 6; k++) exp_q.push_back(8'hFF);
    for (int k = 0; k < 5; k++) begin
      xfer(t[39:32], {name, " frame"});
      t = t << 8;
    end
    xfer(crcb, {name, " frame"});
  endtask

  task automatic read_bytes(input int n, input string name);
    for (int k = 0; k < n; k++) xfer(8'hFF, name);
  endtask

  initial begin
    logic [39:0] t;
    logic [15:0] c16;
    logic [7:0]  junk;
    int s0;

    vecs[0]  = '{"cmd0",       40'h40_0000_0000, 1, 40'h01_0000_0000, 1'b1};
    vecs[1]  = '{"cmd8",       40'h48_0000_01AA, 5, 40'h01_0000_01AA, 1'b1};
    vecs[2]  = '{"cmd55_a",    40'h77_0000_0000, 1, 40'h01_0000_0000, 1'b1};
    vecs[3]  = '{"acmd41_a",   40'h69_4000_0000, 1, 40'h01_0000_0000, 1'b1};
    vecs[4]  = '{"cmd55_b",    40'h77_0000_0000, 1, 40'h01_0000_0000, 1'b1};
    vecs[5]  = '{"acmd41_b",   40'h69_4000_0000, 1, 40'h00_0000_0000, 1'b0};
    vecs[6]  = '{"cmd58",      40'h7A_0000_0000, 5, 40'h00_C0FF_8000, 1'b0};
    vecs[7]  = '{"cmd41_noapp",40'h69_4000_0000, 1, 40'h04_0000_0000, 1'b0};
    vecs[8]  = '{"cmd13",      40'h4D_0000_0000, 1, 40'h04_0000_0000, 1'b0};
    vecs[9]  = '{"cmd55_c",    40'h77_0000_0000, 1, 40'h00_0000_0000, 1'b0};
    vecs[10] = '{"cmd8_b",     40'h48_0000_01AA, 5, 40'h00_0000_01AA, 1'b0};
    vecs[11] = '{"cmd41_late", 40'h69_4000_0000, 1, 40'h04_0000_0000, 1'b0};

    wait_clk(3);
    check("rst miso", {31'h0, sd_miso}, 32'h1);
    check("rst strobe", {31'h0, cmd_strobe}, 32'h0);
    check("rst index", {26'h0, cmd_index}, 32'h0);
    check("rst arg", cmd_arg, 32'h0);
    check("rst idle", {31'h0, card_idle}, 32'h1);
    rst_n = 1'b1;
    wait_clk(4);
    sd_cs_n = 1'b0;
    wait_clk(8);

    // CMD0 with a wrong CRC byte
    s0 = strobe_cnt;
    send_frame(40'h40_0000_0000, 8'h00, "cmd0_badcrc");
    exp_q.push_back(8'hFF);
`ifdef SD_RESP_CRC7_CHECK_EN
    exp_q.push_back(8'h09);
`else
    exp_q.push_back(8'h01);
`endif
    read_bytes(2, "cmd0_badcrc resp");
    wait_clk(2);
    check("cmd0_badcrc strobe", strobe_cnt - s0, 32'd1);
    check("cmd0_badcrc idle", {31'h0, card_idle}, 32'h1);

    for (int v = 0; v < 12; v++) begin
      s0 = strobe_cnt;
      send_frame(vecs[v].frame, crc7_byte(vecs[v].frame), vecs[v].name);
      exp_q.push_back(8'hFF);
      t = vecs[v].resp;
      for (int k = 0; k < int'(vecs[v].nresp); k++) begin
        exp_q.push_back(t[39:32]);
        t = t << 8;
      end
      read_bytes(1 + int'(vecs[v].nresp), {vecs[v].name, " resp"});
      wait_clk(2);
      check({vecs[v].name, " strobe"}, strobe_cnt - s0, 32'd1);
      check({vecs[v].name, " index"}, {26'h0, cmd_index}, {26'h0, vecs[v].frame[37:32]});
      check({vecs[v].name, " arg"}, cmd_arg, vecs[v].frame[31:0]);
      check({vecs[v].name, " idle"}, {31'h0, card_idle}, {31'h0, vecs[v].idle_after});
    end

    // CMD17 aborted by deselect after 100 payload bytes
    send_frame(40'h51_0000_00F0, crc7_byte(40'h51_0000_00F0), "cmd17_a");
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFE);
    for (int k = 0; k < 100; k++) exp_q.push_back(8'(8'hF0 + k));
    read_bytes(105, "cmd17_a read");
    sd_cs_n = 1'b1;
    wait_clk(4);
    for (int k = 0; k < 4; k++) begin
      check("deselect miso", {31'h0, sd_miso}, 32'h1);
      sd_clk = 1'b1;
      wait_clk(4);
      check("deselect miso", {31'h0, sd_miso}, 32'h1);
      sd_clk = 1'b0;
      wait_clk(4);
    end
    check("deselect idle", {31'h0, card_idle}, 32'h0);
    check("deselect queue", exp_q.size(), 32'd0);
    sd_cs_n = 1'b0;
    wait_clk(8);

    // Full CMD17 block after the abort
    s0 = strobe_cnt;
    send_frame(40'h51_0000_00F0, crc7_byte(40'h51_0000_00F0), "cmd17_b");
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFE);
    for (int k = 0; k < 512; k++) exp_q.push_back(8'(8'hF0 + k));
    c16 = crc16_model(8'hF0, 512);
    exp_q.push_back(c16[15:8]);
    exp_q.push_back(c16[7:0]);
    exp_q.push_back(8'hFF);
    read_bytes(5 + 512 + 2 + 1, "cmd17_b read");
    check("cmd17_b strobe", strobe_cnt - s0, 32'd1);
    check("cmd17_b index", {26'h0, cmd_index}, 32'd17);
    check("cmd17_b arg", cmd_arg, 32'h0000_00F0);
    check("cmd17_b idle", {31'h0, card_idle}, 32'h0);

    // Reset in the middle of a frame
    spi_byte(8'h48, junk);
    spi_byte(8'h00, junk);
    spi_byte(8'h00, junk);
    rst_n = 1'b0;
    wait_clk(1);
    check("midrst miso", {31'h0, sd_miso}, 32'h1);
    check("midrst index", {26'h0, cmd_index}, 32'h0);
    check("midrst arg", cmd_arg, 32'h0);
    check("midrst idle", {31'h0, card_idle}, 32'h1);
    rst_n = 1'b1;
    sd_cs_n = 1'b1;
    wait_clk(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
